// File: rtl/instr_phase_sequencer_pkg.sv
// Shared definitions for the instruction phase sequencer: mode encoding,
// phase-counter geometry and the default opcode-latch reset value.
package instr_phase_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_M1 = 2'd0,
    MODE_MR = 2'd1,
    MODE_EX = 2'd2
  } mode_t;

  localparam int              XPT_W   = 4;
  localparam logic [XPT_W-1:0] XPT_MAX = 4'd15;

  localparam logic [7:0] ITABLE_RESET_DEFAULT = 8'h00;

endpackage

// File: rtl/instr_phase_sequencer_if.sv
// Memory handshake, decoder pulses and sequencer status, as seen by the
// sequencer (master) and by the memory/decoder side (slave).
interface instr_phase_sequencer_if #(
  parameter int RETIRE_W = 8
);
  import instr_phase_sequencer_pkg::*;

  logic                MEM_ACK;
  logic [7:0]          DATA_IN;
  logic                PR_Reset_XPT;
  logic                P2_Set_CM1;
  logic                P2_Reset_ITABLE;
  logic                P2_Set_CMR;
  logic                Pa_Ophd;

  logic                DEC_ENABLE;
  logic [XPT_W-1:0]    XPT;
  logic [XPT_W-1:0]    notXPT;
  logic [7:0]          ITABLE;
  logic [7:0]          notITABLE;
  logic [7:0]          OP;
  logic [7:0]          OPold;
  logic                MEM_REQ;
  logic                MODE_M1;
  logic                MODE_MR;
  logic [RETIRE_W-1:0] RETIRED;
  logic                XPT_OVF;

  modport master (
    input  MEM_ACK, DATA_IN, PR_Reset_XPT, P2_Set_CM1, P2_Reset_ITABLE,
           P2_Set_CMR, Pa_Ophd,
    output DEC_ENABLE, XPT, notXPT, ITABLE, notITABLE, OP, OPold, MEM_REQ,
           MODE_M1, MODE_MR, RETIRED, XPT_OVF
  );

  modport slave (
    output MEM_ACK, DATA_IN, PR_Reset_XPT, P2_Set_CM1, P2_Reset_ITABLE,
           P2_Set_CMR, Pa_Ophd,
    input  DEC_ENABLE, XPT, notXPT, ITABLE, notITABLE, OP, OPold, MEM_REQ,
           MODE_M1, MODE_MR, RETIRED, XPT_OVF
  );

endinterface

// File: rtl/instr_phase_sequencer_xpt_counter.sv
// Execution-phase counter: clear beats increment, increment saturates at
// XPT_MAX and records the lost step in a sticky overflow flag.
module instr_phase_sequencer_xpt_counter
  import instr_phase_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [XPT_W-1:0] xpt,
  output logic             ovf
);

  always_ff @(posedge clk) begin
    if (reset) begin
      xpt <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      xpt <= '0;
    end else if (inc) begin
      if (xpt == XPT_MAX) ovf <= 1'b1;
      else                xpt <= xpt + 1'b1;
    end
  end

endmodule

// File: rtl/instr_phase_sequencer.sv
// Fetches opcode/operand bytes over req/ack and runs the execute phase
// that the downstream decoders steer through their control pulses.
//
//   mode    | meaning
//   --------+--------------------------------------------------
//   MODE_M1 | opcode fetch: MEM_REQ high until MEM_ACK
//   MODE_MR | operand fetch: MEM_REQ high until MEM_ACK
//   MODE_EX | execute: decoders enabled, XPT advances per cycle
module instr_phase_sequencer
  import instr_phase_sequencer_pkg::*;
#(
  parameter logic [7:0] ITABLE_RESET = ITABLE_RESET_DEFAULT,
  parameter int         RETIRE_W     = 8
) (
  input logic                     clk,
  input logic                     reset,
  instr_phase_sequencer_if.master bus
);

  mode_t               mode_q, mode_d;
  logic                xpt_clear, xpt_inc;
  logic                load_itable, clr_itable, load_op, retire;
  logic [XPT_W-1:0]    xpt;
  logic                xpt_ovf;
  logic [7:0]          itable_q, op_q, opold_q;
  logic [RETIRE_W-1:0] retired_q;

  always_ff @(posedge clk) begin
    if (reset) mode_q <= MODE_M1;
    else       mode_q <= mode_d;
  end

  always_comb begin
    mode_d      = mode_q;
    xpt_clear   = 1'b0;
    xpt_inc     = 1'b0;
    load_itable = 1'b0;
    clr_itable  = 1'b0;
    load_op     = 1'b0;
    retire      = 1'b0;
    case (mode_q)
      MODE_M1: begin
        if (bus.MEM_ACK) begin
          load_itable = 1'b1;
          xpt_clear   = 1'b1;
          mode_d      = MODE_EX;
        end
      end
      MODE_MR: begin
        if (bus.MEM_ACK) begin
          load_op = 1'b1;
          xpt_inc = 1'b1;
          mode_d  = MODE_EX;
        end
      end
      MODE_EX: begin
        clr_itable = bus.P2_Reset_ITABLE;
        retire     = bus.Pa_Ophd;
        if (bus.P2_Set_CM1) begin
          mode_d    = MODE_M1;
          xpt_clear = 1'b1;
        end else begin
          if (bus.P2_Set_CMR) mode_d = MODE_MR;
          // an XPT reset wins over both the operand-fetch hold and the step
          xpt_clear = bus.PR_Reset_XPT;
          xpt_inc   = !bus.PR_Reset_XPT && !bus.P2_Set_CMR;
        end
      end
      default: mode_d = MODE_M1;
    endcase
  end

  instr_phase_sequencer_xpt_counter u_xpt_counter (
    .clk   (clk),
    .reset (reset),
    .clear (xpt_clear),
    .inc   (xpt_inc),
    .xpt   (xpt),
    .ovf   (xpt_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      itable_q  <= ITABLE_RESET;
      op_q      <= 8'h00;
      opold_q   <= 8'h00;
      retired_q <= '0;
    end else begin
      if (load_itable)     itable_q <= bus.DATA_IN;
      else if (clr_itable) itable_q <= ITABLE_RESET;
      if (load_op) begin
        opold_q <= op_q;
        op_q    <= bus.DATA_IN;
      end
      if (retire) retired_q <= retired_q + 1'b1;
    end
  end

  assign bus.DEC_ENABLE = (mode_q == MODE_EX);
  assign bus.MEM_REQ    = (mode_q == MODE_M1) || (mode_q == MODE_MR);
  assign bus.MODE_M1    = (mode_q == MODE_M1);
  assign bus.MODE_MR    = (mode_q == MODE_MR);
  assign bus.XPT        = xpt;
  assign bus.notXPT     = ~xpt;
  assign bus.ITABLE     = itable_q;
  assign bus.notITABLE  = ~itable_q;
  assign bus.OP         = op_q;
  assign bus.OPold      = opold_q;
  assign bus.RETIRED    = retired_q;
  assign bus.XPT_OVF    = xpt_ovf;

endmodule

// File: tb/tb_instr_phase_sequencer.sv
// Directed scenarios plus randomized traffic checked against a per-cycle
// behavioural model of the sequencer's rules.
module tb_instr_phase_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_phase_sequencer_if #(.RETIRE_W(8)) bus();

  instr_phase_sequencer #(.ITABLE_RESET(8'h00), .RETIRE_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // reference state: mode 0 = opcode fetch, 1 = operand fetch, 2 = execute
  int m_mode, m_xpt, m_itable, m_op, m_opold, m_ret;
  bit m_ovf;

  task automatic clr_in();
    reset               = 1'b0;
    bus.MEM_ACK         = 1'b0;
    bus.DATA_IN         = 8'h00;
    bus.PR_Reset_XPT    = 1'b0;
    bus.P2_Set_CM1      = 1'b0;
    bus.P2_Reset_ITABLE = 1'b0;
    bus.P2_Set_CMR      = 1'b0;
    bus.Pa_Ophd         = 1'b0;
  endtask

  task automatic model_bump();
    if (m_xpt + 1 > 15) m_ovf = 1'b1;
    else                m_xpt = m_xpt + 1;
  endtask

  task automatic model_update();
    if (reset) begin
      m_mode = 0; m_xpt = 0; m_itable = 0; m_op = 0; m_opold = 0;
      m_ret = 0; m_ovf = 1'b0;
    end else if (m_mode == 0) begin
      if (bus.MEM_ACK) begin
        m_itable = int'(bus.DATA_IN); m_xpt = 0; m_mode = 2;
      end
    end else if (m_mode == 1) begin
      if (bus.MEM_ACK) begin
        m_opold = m_op; m_op = int'(bus.DATA_IN); model_bump(); m_mode = 2;
      end
    end else begin
      if (bus.Pa_Ophd) m_ret = (m_ret + 1) % 256;
      if (bus.P2_Reset_ITABLE) m_itable = 0;
      if (bus.P2_Set_CM1) begin
        m_mode = 0; m_xpt = 0;
      end else begin
        if (bus.P2_Set_CMR) m_mode = 1;
        if (bus.PR_Reset_XPT)   m_xpt = 0;
        else if (!bus.P2_Set_CMR) model_bump();
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    clr_in();
    reset = 1'b1;
    step();
    step();
    clr_in();
    vectors++;
    if ({bus.MODE_M1, bus.MODE_MR, bus.MEM_REQ, bus.DEC_ENABLE} !== 4'b1010) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 1010",
               {bus.MODE_M1, bus.MODE_MR, bus.MEM_REQ, bus.DEC_ENABLE});
    end
    vectors++;
    if ({bus.XPT, bus.notXPT} !== 8'h0F) begin
      miscompares++;
      $display("FAIL reset_xpt: got %h expected 0f", {bus.XPT, bus.notXPT});
    end
    vectors++;
    if ({bus.ITABLE, bus.notITABLE} !== 16'h00FF) begin
      miscompares++;
      $display("FAIL reset_itable: got %h expected 00ff", {bus.ITABLE, bus.notITABLE});
    end
    vectors++;
    if ({bus.OP, bus.OPold, bus.RETIRED, bus.XPT_OVF} !== 25'd0) begin
      miscompares++;
      $display("FAIL reset_regs: got %h expected 0",
               {bus.OP, bus.OPold, bus.RETIRED, bus.XPT_OVF});
    end
  endtask

  task automatic test_fetch();
    int req_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      bus.MEM_ACK = (i == 3);
      bus.DATA_IN = (i == 3) ? 8'h07 : 8'($urandom);
      if (bus.MEM_REQ === 1'b1) req_cycles++;
      vectors++;
      if (bus.DEC_ENABLE !== 1'b0) begin
        miscompares++;
        $display("FAIL fetch_dec_low: got %b expected 0 at wait %0d", bus.DEC_ENABLE, i);
      end
      step();
      clr_in();
    end
    vectors++;
    if (req_cycles != 4 || bus.MEM_REQ !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_req: got %0d cycles, req now %b expected 4 cycles, req 0",
               req_cycles, bus.MEM_REQ);
    end
    vectors++;
    if ({bus.ITABLE, bus.notITABLE, bus.XPT, bus.DEC_ENABLE} !== {8'h07, 8'hF8, 4'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL fetch_latch: got itable %h nitable %h xpt %h dec %b expected 07 f8 0 1",
               bus.ITABLE, bus.notITABLE, bus.XPT, bus.DEC_ENABLE);
    end
  endtask

  task automatic test_operand();
    step();
    step();
    vectors++;
    if (bus.XPT !== 4'd2) begin
      miscompares++;
      $display("FAIL operand_xpt_pre: got %0d expected 2", bus.XPT);
    end
    bus.P2_Set_CMR = 1'b1;
    step();
    clr_in();
    vectors++;
    if ({bus.MODE_MR, bus.MEM_REQ, bus.DEC_ENABLE, bus.XPT} !== {3'b110, 4'd2}) begin
      miscompares++;
      $display("FAIL operand_enter_mr: got mr %b req %b dec %b xpt %0d expected 1 1 0 2",
               bus.MODE_MR, bus.MEM_REQ, bus.DEC_ENABLE, bus.XPT);
    end
    // decoder pulses must be ignored while fetching
    bus.Pa_Ophd = 1'b1; bus.PR_Reset_XPT = 1'b1; bus.P2_Set_CM1 = 1'b1;
    step();
    clr_in();
    vectors++;
    if ({bus.MODE_MR, bus.XPT, bus.RETIRED} !== {1'b1, 4'd2, 8'd0}) begin
      miscompares++;
      $display("FAIL operand_ignore_pulses: got mr %b xpt %0d ret %0d expected 1 2 0",
               bus.MODE_MR, bus.XPT, bus.RETIRED);
    end
    bus.MEM_ACK = 1'b1; bus.DATA_IN = 8'h34;
    step();
    clr_in();
    vectors++;
    if ({bus.OP, bus.XPT, bus.DEC_ENABLE} !== {8'h34, 4'd3, 1'b1}) begin
      miscompares++;
      $display("FAIL operand_first: got op %h xpt %0d dec %b expected 34 3 1",
               bus.OP, bus.XPT, bus.DEC_ENABLE);
    end
    bus.PR_Reset_XPT = 1'b1;
    step();
    clr_in();
    step();
    step();
    bus.P2_Set_CMR = 1'b1;
    step();
    clr_in();
    bus.MEM_ACK = 1'b1; bus.DATA_IN = 8'h12;
    step();
    clr_in();
    vectors++;
    if ({bus.OP, bus.OPold, bus.XPT, bus.MODE_M1, bus.MODE_MR} !== {8'h12, 8'h34, 4'd3, 2'b00}) begin
      miscompares++;
      $display("FAIL operand_second: got op %h opold %h xpt %0d m1 %b mr %b expected 12 34 3 0 0",
               bus.OP, bus.OPold, bus.XPT, bus.MODE_M1, bus.MODE_MR);
    end
    bus.MEM_ACK = 1'b1; bus.DATA_IN = 8'hFF;
    step();
    clr_in();
    vectors++;
    if ({bus.OP, bus.ITABLE, bus.XPT} !== {8'h12, 8'h07, 4'd4}) begin
      miscompares++;
      $display("FAIL ex_ack_ignored: got op %h itable %h xpt %0d expected 12 07 4",
               bus.OP, bus.ITABLE, bus.XPT);
    end
  endtask

  task automatic test_cm1_priority();
    bus.P2_Set_CM1 = 1'b1; bus.P2_Reset_ITABLE = 1'b1;
    bus.Pa_Ophd = 1'b1;    bus.P2_Set_CMR = 1'b1;
    step();
    clr_in();
    vectors++;
    if ({bus.MODE_M1, bus.MODE_MR, bus.MEM_REQ, bus.ITABLE, bus.RETIRED, bus.XPT} !==
        {3'b101, 8'h00, 8'd1, 4'd0}) begin
      miscompares++;
      $display("FAIL cm1_priority: got m1 %b mr %b req %b itable %h ret %0d xpt %0d expected 1 0 1 00 1 0",
               bus.MODE_M1, bus.MODE_MR, bus.MEM_REQ, bus.ITABLE, bus.RETIRED, bus.XPT);
    end
    step();
    vectors++;
    if ({bus.MODE_M1, bus.MODE_MR} !== 2'b10) begin
      miscompares++;
      $display("FAIL cm1_no_mr: got m1 %b mr %b expected 1 0", bus.MODE_M1, bus.MODE_MR);
    end
  endtask

  task automatic test_overflow();
    bus.MEM_ACK = 1'b1; bus.DATA_IN = 8'($urandom);
    step();
    clr_in();
    for (int k = 1; k <= 20; k++) begin
      step();
      vectors++;
      if (bus.XPT !== 4'((k > 15) ? 15 : k) || bus.XPT_OVF !== (k > 15)) begin
        miscompares++;
        $display("FAIL overflow_step%0d: got xpt %0d ovf %b expected %0d %b",
                 k, bus.XPT, bus.XPT_OVF, (k > 15) ? 15 : k, k > 15);
      end
    end
    bus.P2_Set_CM1 = 1'b1;
    step();
    clr_in();
    bus.MEM_ACK = 1'b1; bus.DATA_IN = 8'h5C;
    step();
    clr_in();
    vectors++;
    if ({bus.XPT_OVF, bus.XPT} !== {1'b1, 4'd0}) begin
      miscompares++;
      $display("FAIL overflow_sticky: got ovf %b xpt %0d expected 1 0", bus.XPT_OVF, bus.XPT);
    end
  endtask

  task automatic test_random();
    logic [52:0] obs, exp_v;
    for (int n = 0; n < 3000; n++) begin
      reset               = ($urandom % 64) == 0;
      bus.MEM_ACK         = ($urandom % 3) == 0;
      bus.DATA_IN         = 8'($urandom);
      bus.P2_Set_CM1      = ($urandom % 12) == 0;
      bus.P2_Set_CMR      = ($urandom % 8) == 0;
      bus.PR_Reset_XPT    = ($urandom % 10) == 0;
      bus.P2_Reset_ITABLE = ($urandom % 10) == 0;
      bus.Pa_Ophd         = ($urandom % 6) == 0;
      step();
      obs = {bus.DEC_ENABLE, bus.MEM_REQ, bus.MODE_M1, bus.MODE_MR, bus.XPT, bus.notXPT,
             bus.ITABLE, bus.notITABLE, bus.OP, bus.OPold, bus.RETIRED, bus.XPT_OVF};
      exp_v = {m_mode == 2, m_mode != 2, m_mode == 0, m_mode == 1, 4'(m_xpt), ~4'(m_xpt),
               8'(m_itable), ~8'(m_itable), 8'(m_op), 8'(m_opold), 8'(m_ret), m_ovf};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL random_cycle%0d: got %h expected %h", n, obs, exp_v);
      end
    end
    clr_in();
  endtask

  task automatic test_reset_mid_fetch();
    reset = 1'b1;
    step();
    clr_in();
    bus.MEM_ACK = 1'b1; bus.DATA_IN = 8'h5A;
    step();
    clr_in();
    bus.Pa_Ophd = 1'b1;
    step();
    clr_in();
    bus.P2_Set_CMR = 1'b1;
    step();
    clr_in();
    vectors++;
    if ({bus.MODE_MR, bus.RETIRED, bus.XPT} !== {1'b1, 8'd1, 4'd1}) begin
      miscompares++;
      $display("FAIL midfetch_setup: got mr %b ret %0d xpt %0d expected 1 1 1",
               bus.MODE_MR, bus.RETIRED, bus.XPT);
    end
    reset = 1'b1; bus.MEM_ACK = 1'b1; bus.DATA_IN = 8'hAA;
    step();
    clr_in();
    vectors++;
    if ({bus.MODE_M1, bus.MODE_MR, bus.MEM_REQ, bus.OP, bus.XPT, bus.RETIRED} !==
        {3'b101, 8'h00, 4'd0, 8'd0}) begin
      miscompares++;
      $display("FAIL midfetch_reset: got m1 %b mr %b req %b op %h xpt %0d ret %0d expected 1 0 1 00 0 0",
               bus.MODE_M1, bus.MODE_MR, bus.MEM_REQ, bus.OP, bus.XPT, bus.RETIRED);
    end
    step();
    vectors++;
    if ({bus.MODE_M1, bus.ITABLE} !== {1'b1, 8'h00}) begin
      miscompares++;
      $display("FAIL midfetch_ack_dropped: got m1 %b itable %h expected 1 00",
               bus.MODE_M1, bus.ITABLE);
    end
  endtask

  task automatic test_retire_wrap();
    for (int n = 0; n < 256; n++) begin
      int waits = $urandom % 3;
      for (int w = 0; w < waits; w++) step();
      bus.MEM_ACK = 1'b1; bus.DATA_IN = 8'($urandom);
      step();
      clr_in();
      bus.Pa_Ophd = 1'b1; bus.P2_Set_CM1 = 1'b1;
      step();
      clr_in();
      if (n == 254) begin
        vectors++;
        if (bus.RETIRED !== 8'd255) begin
          miscompares++;
          $display("FAIL retire_255: got %0d expected 255", bus.RETIRED);
        end
      end
    end
    vectors++;
    if (bus.RETIRED !== 8'd0 || m_ret != 0) begin
      miscompares++;
      $display("FAIL retire_wrap: got %0d expected 0 (model %0d)", bus.RETIRED, m_ret);
    end
  endtask

  initial begin
    clr_in();
    m_mode = 0; m_xpt = 0; m_itable = 0; m_op = 0; m_opold = 0; m_ret = 0; m_ovf = 1'b0;
    #2;
    test_reset();
    test_fetch();
    test_operand();
    test_cm1_priority();
    test_overflow();
    test_random();
    test_reset_mid_fetch();
    test_retire_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
